pbs_battle_dp_gen: RTL and testbench

Parametrised next-generation battle datapath for the PBS game, sitting between the battle control FSM and the HP display logic.
- Replaces the free-running per-bit ring-oscillator randomness with one seedable 16-bit LFSR.
- Generalises HP width, heal amount and move table.
- Adds an internal turn sequencer: player action, then AI counter-attack, then a done pulse, all from one start handshake.
- Deterministic under seed load plus stop, so benches can predict every roll.

---
 rtl/pbs_battle_dp_gen.sv | 146 ++++++++++++++
 tb/tb_pbs_battle_dp_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pbs_battle_dp_gen.sv
// rtl/pbs_battle_dp_gen.sv - PBS battle datapath: seedable LFSR, HP registers, turn sequencer
// One start handshake runs player action, AI counter-attack, then a one-cycle turn_done.
module pbs_battle_dp_gen #(
   parameter int HP_W     = 4,
   parameter int MAX_HP   = 15,
   parameter int HEAL_AMT = 5,
   parameter int MOVE_W   = 2,
   parameter int ACC_W    = 4,
   parameter logic [(2**MOVE_W)*HP_W-1:0]  DMG_TABLE = {4'd8, 4'd5, 4'd3, 4'd2},
   parameter logic [(2**MOVE_W)*ACC_W-1:0] ACC_TABLE = {4'd4, 4'd8, 4'd12, 4'd15},
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stop,
   input  logic              seed_load,
   input  logic [15:0]       seed,
   input  logic              new_battle,
   input  logic              turn_start,
   input  logic              p_heal,
   input  logic [MOVE_W-1:0] p_move,
   output logic              busy,
   output logic              turn_done,
   output logic [HP_W-1:0]   p_hp,
   output logic [HP_W-1:0]   ai_hp,
   output logic              p_dead,
   output logic              ai_dead,
   output logic              p_hit,
   output logic              ai_hit,
   output logic [MOVE_W-1:0] ai_move
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_P_ACT  = 2'd1;
   localparam logic [1:0] S_AI_ACT = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [HP_W-1:0] HP_MAX   = HP_W'(MAX_HP);
   localparam logic [HP_W:0]   MAX_EXT  = (HP_W+1)'(MAX_HP);
   localparam logic [HP_W:0]   HEAL_EXT = (HP_W+1)'(HEAL_AMT);

   function automatic logic [HP_W-1:0] dmg_of(input logic [MOVE_W-1:0] m);
      return DMG_TABLE[int'(m)*HP_W +: HP_W];
   endfunction

   function automatic logic [ACC_W-1:0] acc_of(input logic [MOVE_W-1:0] m);
      return ACC_TABLE[int'(m)*ACC_W +: ACC_W];
   endfunction

   function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a, input logic [HP_W-1:0] b);
      return (b > a) ? '0 : a - b;
   endfunction

   logic [1:0]        state;
   logic [15:0]       lfsr;
   logic [15:0]       lfsr_next;
   logic              heal_q;
   logic [MOVE_W-1:0] move_q;

   logic [ACC_W-1:0]  roll;
   logic [MOVE_W-1:0] ai_pick;
   logic              p_roll_hit;
   logic              ai_roll_hit;
   logic [HP_W-1:0]   ai_hp_hit;
   logic [HP_W-1:0]   p_hp_hit;
   logic [HP_W:0]     heal_sum;
   logic [HP_W-1:0]   heal_hp;

   assign busy    = (state != S_IDLE);
   assign p_dead  = (p_hp == '0);
   assign ai_dead = (ai_hp == '0);

   // Both roll and AI pick come from the current register, so a frozen LFSR repeats them.
   assign roll    = lfsr[ACC_W-1:0];
   assign ai_pick = lfsr[ACC_W+MOVE_W-1:ACC_W];

   assign lfsr_next   = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
   assign p_roll_hit  = (roll < acc_of(move_q));
   assign ai_roll_hit = (roll < acc_of(ai_pick));
   assign ai_hp_hit   = sat_sub(ai_hp, dmg_of(move_q));
   assign p_hp_hit    = sat_sub(p_hp, dmg_of(ai_pick));
   assign heal_sum    = {1'b0, p_hp} + HEAL_EXT;
   assign heal_hp     = (heal_sum > MAX_EXT) ? HP_MAX : heal_sum[HP_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         lfsr      <= LFSR_SEED;
         p_hp      <= HP_MAX;
         ai_hp     <= HP_MAX;
         heal_q    <= 1'b0;
         move_q    <= '0;
         turn_done <= 1'b0;
         p_hit     <= 1'b0;
         ai_hit    <= 1'b0;
         ai_move   <= '0;
      end else begin
         turn_done <= (state == S_DONE);

         if (seed_load)
            lfsr <= (seed == 16'h0000) ? LFSR_SEED : seed;
         else if (!stop)
            lfsr <= lfsr_next;

         case (state)
            S_IDLE: begin
               if (turn_start && !p_dead && !ai_dead) begin
                  heal_q <= p_heal;
                  move_q <= p_move;
                  p_hit  <= 1'b0;
                  ai_hit <= 1'b0;
                  state  <= S_P_ACT;
               end else if (new_battle) begin
                  p_hp    <= HP_MAX;
                  ai_hp   <= HP_MAX;
                  p_hit   <= 1'b0;
                  ai_hit  <= 1'b0;
                  ai_move <= '0;
               end
            end
            S_P_ACT: begin
               if (heal_q) begin
                  p_hp  <= heal_hp;
                  state <= S_AI_ACT;
               end else begin
                  p_hit <= p_roll_hit;
                  if (p_roll_hit)
                     ai_hp <= ai_hp_hit;
                  // A knocked-out AI gets no counter-attack.
                  state <= (p_roll_hit && ai_hp_hit == '0) ? S_DONE : S_AI_ACT;
               end
            end
            S_AI_ACT: begin
               ai_move <= ai_pick;
               ai_hit  <= ai_roll_hit;
               if (ai_roll_hit)
                  p_hp <= p_hp_hit;
               state <= S_DONE;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pbs_battle_dp_gen.sv
// tb/tb_pbs_battle_dp_gen.sv - directed bench for pbs_battle_dp_gen with hand-computed rolls
module tb_pbs_battle_dp_gen;

   logic        clk = 1'b0;
   logic        rst, stop, seed_load, new_battle, turn_start, p_heal;
   logic [15:0] seed;
   logic [1:0]  p_move;
   logic        busy, turn_done, p_dead, ai_dead, p_hit, ai_hit;
   logic [3:0]  p_hp, ai_hp;
   logic [1:0]  ai_move;

   int n_checks = 0;
   int n_err    = 0;
   logic [3:0] mid_p_hp;

   always #5 clk = ~clk;

   pbs_battle_dp_gen dut (
      .clk(clk), .rst(rst), .stop(stop), .seed_load(seed_load), .seed(seed),
      .new_battle(new_battle), .turn_start(turn_start), .p_heal(p_heal), .p_move(p_move),
      .busy(busy), .turn_done(turn_done), .p_hp(p_hp), .ai_hp(ai_hp),
      .p_dead(p_dead), .ai_dead(ai_dead), .p_hit(p_hit), .ai_hit(ai_hit), .ai_move(ai_move)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_seed(input logic [15:0] s);
      seed_load = 1'b1;
      seed      = s;
      tick();
      seed_load = 1'b0;
   endtask

   task automatic fresh_battle();
      new_battle = 1'b1;
      tick();
      new_battle = 1'b0;
   endtask

   task automatic do_turn(input string tag, input logic heal, input logic [1:0] mv, input int exp_cyc);
      int cyc;
      turn_start = 1'b1;
      p_heal     = heal;
      p_move     = mv;
      tick();
      turn_start = 1'b0;
      p_heal     = 1'b0;
      p_move     = 2'd0;
      check({tag, ".busy"}, busy, 1);
      cyc = 0;
      while (cyc < 8) begin
         tick();
         cyc++;
         if (cyc == 1) mid_p_hp = p_hp;
         if (turn_done) break;
      end
      check({tag, ".latency"}, cyc, exp_cyc);
   endtask

   task automatic check_result(input string tag, input int php, input int aihp,
                               input int ph, input int ah, input int am);
      check({tag, ".p_hp"}, p_hp, php);
      check({tag, ".ai_hp"}, ai_hp, aihp);
      check({tag, ".p_hit"}, p_hit, ph);
      check({tag, ".ai_hit"}, ai_hit, ah);
      check({tag, ".ai_move"}, ai_move, am);
   endtask

   initial begin
      int pulses;
      rst = 1'b1; stop = 1'b1; seed_load = 1'b0; seed = 16'h0; new_battle = 1'b0;
      turn_start = 1'b0; p_heal = 1'b0; p_move = 2'd0;
      tick(); tick();
      rst = 1'b0;
      check("rst.p_hp", p_hp, 15);
      check("rst.ai_hp", ai_hp, 15);
      check("rst.busy", busy, 0);
      check("rst.p_dead", p_dead, 0);
      check("rst.ai_dead", ai_dead, 0);
      check("rst.turn_done", turn_done, 0);
      check("rst.ai_move", ai_move, 0);

      // lfsr=ACE1 frozen: roll 1, pick 2; move3 hits for 8, AI move2 (acc 8) hits for 5
      do_turn("seed_rst", 1'b0, 2'd3, 3);
      check_result("seed_rst", 10, 7, 1, 1, 2);
      tick();
      check("seed_rst.pulse", turn_done, 0);

      fresh_battle();
      check_result("newb", 15, 15, 0, 0, 0);

      // 0x0013: roll 3, pick 1
      load_seed(16'h0013);
      do_turn("t13", 1'b0, 2'd0, 3);
      check_result("t13", 12, 13, 1, 1, 1);

      do_turn("heal", 1'b1, 2'd0, 3);
      check("heal.mid_clamp", mid_p_hp, 15);
      check_result("heal", 12, 13, 0, 1, 1);

      // 0x000C: roll 12, pick 0; move3 acc4 misses, AI move0 hits for 2
      load_seed(16'h000C);
      do_turn("miss", 1'b0, 2'd3, 3);
      check_result("miss", 10, 13, 0, 1, 0);

      // 0x000F: roll 15 misses even with accuracy 15
      load_seed(16'h000F);
      do_turn("maxroll", 1'b0, 2'd0, 3);
      check_result("maxroll", 10, 13, 0, 0, 0);

      // 0x0001: roll 1, pick 0; move2 takes ai to 8, then move3 KOs
      load_seed(16'h0001);
      do_turn("to8", 1'b0, 2'd2, 3);
      check_result("to8", 8, 8, 1, 1, 0);
      do_turn("ko", 1'b0, 2'd3, 2);
      check("ko.mid_p_hp", mid_p_hp, 8);
      check_result("ko", 8, 0, 1, 0, 0);
      check("ko.ai_dead", ai_dead, 1);

      turn_start = 1'b1;
      tick();
      turn_start = 1'b0;
      check("dead.busy", busy, 0);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (turn_done) pulses++;
      end
      check("dead.no_done", pulses, 0);
      fresh_battle();
      check("dead.newb_p_hp", p_hp, 15);
      check("dead.newb_ai_hp", ai_hp, 15);
      check("dead.newb_ai_dead", ai_dead, 0);

      // reset while in AI_ACT
      turn_start = 1'b1; p_move = 2'd0;
      tick();
      turn_start = 1'b0;
      tick();
      check("midrst.ai_hp_pre", ai_hp, 13);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst.busy", busy, 0);
      check("midrst.p_hp", p_hp, 15);
      check("midrst.ai_hp", ai_hp, 15);
      check("midrst.turn_done", turn_done, 0);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (turn_done) pulses++;
      end
      check("midrst.no_done", pulses, 0);
      do_turn("midrst_seed", 1'b0, 2'd3, 3);
      check_result("midrst_seed", 10, 7, 1, 1, 2);

      // seed 0 substitutes ACE1
      fresh_battle();
      load_seed(16'h0013);
      load_seed(16'h0000);
      do_turn("seed0", 1'b0, 2'd3, 3);
      check_result("seed0", 10, 7, 1, 1, 2);

      // one free-running step: 0x0013 -> 0xB409 (roll 9, pick 0)
      fresh_battle();
      stop = 1'b0;
      load_seed(16'h0013);
      tick();
      stop = 1'b1;
      do_turn("adv", 1'b0, 2'd1, 3);
      check_result("adv", 13, 12, 1, 1, 0);

      // inputs while busy are ignored: one turn, original move and action
      fresh_battle();
      load_seed(16'h0013);
      turn_start = 1'b1; p_move = 2'd0; p_heal = 1'b0;
      tick();
      p_move = 2'd3; p_heal = 1'b1; new_battle = 1'b1;
      tick();
      tick();
      turn_start = 1'b0; p_move = 2'd0; p_heal = 1'b0; new_battle = 1'b0;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         if (turn_done) pulses++;
         tick();
      end
      check("busy_ign.pulses", pulses, 1);
      check_result("busy_ign", 12, 13, 1, 1, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
